// File: rtl/mf8_pcctl_if.sv
// mf8_pcctl_if: decode/PC-unit bundle seen by the mf8 control-flow sequencer.
//   master : decode stage + PC unit (drives instruction, PC, interrupt request)
//   slave  : mf8_pcctl (drives Pause/RJmp/Offs_Out, Irq_Ack, Ie, Stk_Err)
// STALL_W must match the STALL_W of the mf8_pcctl instance it is bound to.
interface mf8_pcctl_if #(parameter int STALL_W = 2);
  logic               Inst_Valid;
  logic [2:0]         Inst_Kind;
  logic [11:0]        Inst_Offs;
  logic               Br_Taken;
  logic [STALL_W-1:0] Stall_Cycles;
  logic [11:0]        PC;
  logic               Irq_Req;
  logic [11:0]        Irq_Vec;
  logic               Pause;
  logic               RJmp;
  logic [11:0]        Offs_Out;
  logic               Irq_Ack;
  logic               Ie;
  logic               Stk_Err;

  modport master (
    output Inst_Valid, Inst_Kind, Inst_Offs, Br_Taken, Stall_Cycles, PC, Irq_Req, Irq_Vec,
    input  Pause, RJmp, Offs_Out, Irq_Ack, Ie, Stk_Err
  );

  modport slave (
    input  Inst_Valid, Inst_Kind, Inst_Offs, Br_Taken, Stall_Cycles, PC, Irq_Req, Irq_Vec,
    output Pause, RJmp, Offs_Out, Irq_Ack, Ie, Stk_Err
  );
endinterface

// File: rtl/mf8_pcctl.sv
// mf8_pcctl: control-flow sequencer for the mf8 program counter unit.
// Classifies the decoded instruction each cycle and drives the PC unit's
// Pause/RJmp/Offs_Out combinationally. Owns the hardware return stack
// (RCALL/RET/RETI), the MULTI stall counter and interrupt entry. Absolute
// targets (return addresses, vectors) are turned into PC-relative offsets.
//
// Ports:
//   Clk   - clock
//   Reset - synchronous, active-high
//   bus   - mf8_pcctl_if.slave: instruction/PC/interrupt inputs,
//           Pause/RJmp/Offs_Out/Irq_Ack/Ie/Stk_Err outputs
//
// Build option: define MF8_PCCTL_STKCHK_EN for a checked stack (overflow and
// underflow are refused and flagged on Stk_Err, interrupts deferred while the
// stack is full). Undefined: Stk_Err is 0 and the stack pointer wraps mod DEPTH.
module mf8_pcctl #(
  parameter int DEPTH   = 4,   // return-stack entries, 2..16
  parameter int STALL_W = 2
) (
  input logic       Clk,
  input logic       Reset,
  mf8_pcctl_if.slave bus
);

  localparam int IW  = $clog2(DEPTH);
  localparam int SPW = $clog2(DEPTH + 1);

  localparam logic [2:0] K_NORMAL = 3'd0;
  localparam logic [2:0] K_MULTI  = 3'd1;
  localparam logic [2:0] K_RJMP   = 3'd2;
  localparam logic [2:0] K_BRANCH = 3'd3;
  localparam logic [2:0] K_RCALL  = 3'd4;
  localparam logic [2:0] K_RET    = 3'd5;
  localparam logic [2:0] K_RETI   = 3'd6;
  localparam logic [2:0] K_SEI    = 3'd7;

  typedef enum logic {S_RUN, S_STALL} state_t;

  state_t                   state_q, state_d;
  logic [STALL_W-1:0]       cnt_q, cnt_d;
  logic [SPW-1:0]           sp_q, sp_d;
  logic [DEPTH-1:0][11:0]   stk_q, stk_d;
  logic                     ie_q, ie_d;
`ifdef MF8_PCCTL_STKCHK_EN
  logic                     err_q, err_d;
  logic                     full, empty;
`endif

  logic                     pause, rjmp, ack;
  logic [11:0]              offs;
  logic                     push, pop;
  logic [11:0]              push_val;
  logic [IW-1:0]            pop_idx;
  logic [11:0]              pop_val;
  logic                     pop_ok;     // pop yields a usable return address
  logic                     irq_block;  // interrupt entry refused this cycle
  logic [11:0]              jmp_offs;

  // Stack status and the entry a pop would return.
`ifdef MF8_PCCTL_STKCHK_EN
  assign full      = (sp_q == SPW'(DEPTH));
  assign empty     = (sp_q == '0);
  assign pop_ok    = !empty;
  assign irq_block = full;
  assign pop_idx   = IW'(sp_q - SPW'(1));
`else
  assign pop_ok    = 1'b1;
  assign irq_block = 1'b0;
  // Circular stack: popping an empty stack wraps to the top slot.
  assign pop_idx   = (sp_q == '0) ? IW'(DEPTH - 1) : IW'(sp_q - SPW'(1));
`endif
  assign pop_val  = stk_q[pop_idx];
  // Relative jumps land on PC+k+1.
  assign jmp_offs = bus.Inst_Offs + 12'd1;

  always_comb begin
    pause    = 1'b1;
    rjmp     = 1'b0;
    offs     = '0;
    ack      = 1'b0;
    state_d  = state_q;
    cnt_d    = cnt_q;
    sp_d     = sp_q;
    stk_d    = stk_q;
    ie_d     = ie_q;
`ifdef MF8_PCCTL_STKCHK_EN
    err_d    = err_q;
`endif
    push     = 1'b0;
    pop      = 1'b0;
    push_val = '0;

    // During Reset the defaults (hold PC, no jump) are what the PC unit sees.
    if (!Reset) begin
      unique case (state_q)
        S_RUN: begin
          if (bus.Irq_Req && ie_q && !irq_block) begin
            // Interrupt entry beats any instruction; the instruction at PC
            // is not executed and PC itself is the return address.
            push     = 1'b1;
            push_val = bus.PC;
            pause    = 1'b0;
            rjmp     = 1'b1;
            offs     = bus.Irq_Vec - bus.PC;
            ack      = 1'b1;
            ie_d     = 1'b0;
          end else if (bus.Inst_Valid) begin
            case (bus.Inst_Kind)
              K_NORMAL: pause = 1'b0;
              K_SEI: begin
                pause = 1'b0;
                ie_d  = 1'b1;
              end
              K_MULTI: begin
                if (bus.Stall_Cycles == '0) begin
                  pause = 1'b0;
                end else begin
                  // This cycle plus n more; PC advances on the last one.
                  cnt_d   = bus.Stall_Cycles - STALL_W'(1);
                  state_d = S_STALL;
                end
              end
              K_RJMP: begin
                pause = 1'b0;
                rjmp  = 1'b1;
                offs  = jmp_offs;
              end
              K_BRANCH: begin
                pause = 1'b0;
                if (bus.Br_Taken) begin
                  rjmp = 1'b1;
                  offs = jmp_offs;
                end
              end
              K_RCALL: begin
                push     = 1'b1;
                push_val = bus.PC + 12'd1;
                pause    = 1'b0;
                rjmp     = 1'b1;
                offs     = jmp_offs;
              end
              K_RET, K_RETI: begin
                pop   = 1'b1;
                pause = 1'b0;
                if (pop_ok) begin
                  rjmp = 1'b1;
                  offs = pop_val - bus.PC;
                end
                if (bus.Inst_Kind == K_RETI) ie_d = 1'b1;
              end
            endcase
          end
        end
        S_STALL: begin
          // Instruction inputs and Irq_Req are ignored until back in RUN.
          if (cnt_q != '0) begin
            cnt_d = cnt_q - STALL_W'(1);
          end else begin
            pause   = 1'b0;
            state_d = S_RUN;
          end
        end
      endcase
    end

    if (push) begin
`ifdef MF8_PCCTL_STKCHK_EN
      if (full) begin
        err_d = 1'b1;
      end else begin
        stk_d[IW'(sp_q)] = push_val;
        sp_d             = sp_q + SPW'(1);
      end
`else
      // Full stack: wrap and overwrite the oldest entry.
      stk_d[IW'(sp_q)] = push_val;
      sp_d             = (sp_q == SPW'(DEPTH - 1)) ? '0 : sp_q + SPW'(1);
`endif
    end else if (pop) begin
`ifdef MF8_PCCTL_STKCHK_EN
      if (empty) err_d = 1'b1;
      else       sp_d  = sp_q - SPW'(1);
`else
      sp_d = (sp_q == '0) ? SPW'(DEPTH - 1) : sp_q - SPW'(1);
`endif
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      sp_q    <= '0;
      ie_q    <= 1'b0;
`ifdef MF8_PCCTL_STKCHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sp_q    <= sp_d;
      stk_q   <= stk_d;
      ie_q    <= ie_d;
`ifdef MF8_PCCTL_STKCHK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign bus.Pause    = pause;
  assign bus.RJmp     = rjmp;
  assign bus.Offs_Out = offs;
  assign bus.Irq_Ack  = ack;
  assign bus.Ie       = ie_q;
`ifdef MF8_PCCTL_STKCHK_EN
  assign bus.Stk_Err  = err_q;
`else
  assign bus.Stk_Err  = 1'b0;
`endif

endmodule

// File: tb/tb_mf8_pcctl.sv
// tb_mf8_pcctl: vector table plus hand-written multi-cycle sequences for
// mf8_pcctl (DEPTH=4, STALL_W=2). Expectations are queued when a row is
// driven and compared when the outputs are sampled on the falling edge.
module tb_mf8_pcctl;

  localparam logic [2:0] N = 3'd0, M = 3'd1, J = 3'd2, B = 3'd3;
  localparam logic [2:0] C = 3'd4, R = 3'd5, I = 3'd6, S = 3'd7;

`ifdef MF8_PCCTL_STKCHK_EN
  localparam logic EM = 1'b1;
`else
  localparam logic EM = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  mf8_pcctl_if #(.STALL_W(2)) bus ();
  mf8_pcctl #(.DEPTH(4), .STALL_W(2)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  typedef struct {
    logic        rst, vld;
    logic [2:0]  kind;
    logic [11:0] offs;
    logic        br;
    logic [1:0]  stl;
    logic [11:0] pc;
    logic        irq;
    logic [11:0] vec;
    logic        e_pause, e_rjmp;
    logic [11:0] e_offs;
    logic        e_ack, e_ie, e_err;
  } vec_t;

  typedef struct {
    logic        pause, rjmp;
    logic [11:0] offs;
    logic        ack, ie, err;
    logic        chk_offs;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic vec_t mk(logic rst, logic vld, logic [2:0] kind, logic [11:0] offs,
                              logic br, logic [1:0] stl, logic [11:0] pc, logic irq,
                              logic [11:0] vec, logic p, logic j, logic [11:0] o,
                              logic a, logic ie, logic err);
    vec_t v;
    v.rst = rst; v.vld = vld; v.kind = kind; v.offs = offs; v.br = br; v.stl = stl;
    v.pc = pc; v.irq = irq; v.vec = vec;
    v.e_pause = p; v.e_rjmp = j; v.e_offs = o; v.e_ack = a; v.e_ie = ie; v.e_err = err;
    return v;
  endfunction

  task automatic chk(string name, logic [11:0] act, logic [11:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
  endtask

  // Drive one row (just after a rising edge), queue its expectation, then
  // compare on the falling edge and advance to just after the next rising edge.
  task automatic step(string tag, vec_t v);
    exp_t e;
    Reset            = v.rst;
    bus.Inst_Valid   = v.vld;
    bus.Inst_Kind    = v.kind;
    bus.Inst_Offs    = v.offs;
    bus.Br_Taken     = v.br;
    bus.Stall_Cycles = v.stl;
    bus.PC           = v.pc;
    bus.Irq_Req      = v.irq;
    bus.Irq_Vec      = v.vec;
    e.pause = v.e_pause; e.rjmp = v.e_rjmp; e.offs = v.e_offs;
    e.ack = v.e_ack; e.ie = v.e_ie; e.err = v.e_err;
    e.chk_offs = v.e_rjmp | v.rst;
    sb.push_back(e);
    @(negedge Clk);
    if (sb.size() == 0) begin
      n_chk++;
      $display("FAIL %s.sb: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".pause"}, {11'b0, bus.Pause},   {11'b0, e.pause});
      chk({tag, ".rjmp"},  {11'b0, bus.RJmp},    {11'b0, e.rjmp});
      if (e.chk_offs) chk({tag, ".offs"}, bus.Offs_Out, e.offs);
      chk({tag, ".ack"},   {11'b0, bus.Irq_Ack}, {11'b0, e.ack});
      chk({tag, ".ie"},    {11'b0, bus.Ie},      {11'b0, e.ie});
      chk({tag, ".err"},   {11'b0, bus.Stk_Err}, {11'b0, e.err});
    end
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset = 1'b1;
    bus.Inst_Valid = 1'b0; bus.Inst_Kind = N; bus.Inst_Offs = '0; bus.Br_Taken = 1'b0;
    bus.Stall_Cycles = '0; bus.PC = '0; bus.Irq_Req = 1'b0; bus.Irq_Vec = '0;
    repeat (2) @(posedge Clk);
    #1;

    //              rst vld kind offs    br stl pc       irq vec      | P  J  offs    A  Ie Err
    tbl.push_back(mk(1, 1, N, 12'h000, 0, 0, 12'h000, 0, 12'h000,   1, 0, 12'h000, 0, 0, 0));
    tbl.push_back(mk(0, 1, N, 12'h000, 0, 0, 12'h000, 0, 12'h000,   0, 0, 12'h000, 0, 0, 0));
    tbl.push_back(mk(0, 1, N, 12'h000, 0, 0, 12'h001, 0, 12'h000,   0, 0, 12'h000, 0, 0, 0));
    tbl.push_back(mk(0, 1, N, 12'h000, 0, 0, 12'h002, 0, 12'h000,   0, 0, 12'h000, 0, 0, 0));
    tbl.push_back(mk(0, 1, J, 12'hFFE, 0, 0, 12'h010, 0, 12'h000,   0, 1, 12'hFFF, 0, 0, 0));
    tbl.push_back(mk(0, 1, B, 12'h005, 0, 0, 12'h00F, 0, 12'h000,   0, 0, 12'h000, 0, 0, 0));
    tbl.push_back(mk(0, 1, B, 12'h005, 1, 0, 12'h010, 0, 12'h000,   0, 1, 12'h006, 0, 0, 0));
    tbl.push_back(mk(0, 1, C, 12'h00F, 0, 0, 12'h020, 0, 12'h000,   0, 1, 12'h010, 0, 0, 0));
    tbl.push_back(mk(0, 1, R, 12'h000, 0, 0, 12'h030, 0, 12'h000,   0, 1, 12'hFF1, 0, 0, 0));
    tbl.push_back(mk(0, 0, N, 12'h000, 0, 0, 12'h031, 0, 12'h000,   1, 0, 12'h000, 0, 0, 0));
    tbl.push_back(mk(0, 1, S, 12'h000, 0, 0, 12'h031, 0, 12'h000,   0, 0, 12'h000, 0, 0, 0));
    tbl.push_back(mk(0, 1, N, 12'h000, 0, 0, 12'h032, 0, 12'h000,   0, 0, 12'h000, 0, 1, 0));
    // Interrupt with no valid instruction: vector 0x100 from PC 0x033.
    tbl.push_back(mk(0, 0, N, 12'h000, 0, 0, 12'h033, 1, 12'h100,   0, 1, 12'h0CD, 1, 1, 0));
    tbl.push_back(mk(0, 1, N, 12'h000, 0, 0, 12'h100, 1, 12'h100,   0, 0, 12'h000, 0, 0, 0));
    tbl.push_back(mk(0, 1, I, 12'h000, 0, 0, 12'h101, 0, 12'h000,   0, 1, 12'hF32, 0, 0, 0));
    tbl.push_back(mk(0, 1, N, 12'h000, 0, 0, 12'h033, 0, 12'h000,   0, 0, 12'h000, 0, 1, 0));
    // Five nested calls into a 4-deep stack, then one return.
    tbl.push_back(mk(0, 1, C, 12'h00F, 0, 0, 12'h050, 0, 12'h000,   0, 1, 12'h010, 0, 1, 0));
    tbl.push_back(mk(0, 1, C, 12'h00F, 0, 0, 12'h060, 0, 12'h000,   0, 1, 12'h010, 0, 1, 0));
    tbl.push_back(mk(0, 1, C, 12'h00F, 0, 0, 12'h070, 0, 12'h000,   0, 1, 12'h010, 0, 1, 0));
    tbl.push_back(mk(0, 1, C, 12'h00F, 0, 0, 12'h080, 0, 12'h000,   0, 1, 12'h010, 0, 1, 0));
    tbl.push_back(mk(0, 1, C, 12'h00F, 0, 0, 12'h090, 0, 12'h000,   0, 1, 12'h010, 0, 1, 0));
    tbl.push_back(mk(0, 1, R, 12'h000, 0, 0, 12'h0A0, 0, 12'h000,
                     0, 1, EM ? 12'hFE1 : 12'hFF1, 0, 1, EM));
`ifndef MF8_PCCTL_STKCHK_EN
    // Empty circular stack: pop wraps to slot 3, written by the 4th call (0x081).
    tbl.push_back(mk(0, 1, R, 12'h000, 0, 0, 12'h0A1, 0, 12'h000,   0, 1, 12'hFE0, 0, 1, 0));
`endif

    foreach (tbl[k]) step($sformatf("row%0d", k), tbl[k]);

    // MULTI n=2 with an interrupt raised mid-stall: taken only back in RUN.
    step("stl0", mk(0, 1, M, 12'h000, 0, 2, 12'h040, 0, 12'h000,   1, 0, 12'h000, 0, 1, EM));
    step("stl1", mk(0, 1, J, 12'h123, 0, 0, 12'h041, 1, 12'h200,   1, 0, 12'h000, 0, 1, EM));
    step("stl2", mk(0, 1, J, 12'h123, 0, 0, 12'h041, 1, 12'h200,   0, 0, 12'h000, 0, 1, EM));
    step("irq0", mk(0, 1, N, 12'h000, 0, 0, 12'h041, 1, 12'h200,   0, 1, 12'h1BF, 1, 1, EM));
    step("irq1", mk(0, 1, R, 12'h000, 0, 0, 12'h200, 0, 12'h000,   0, 1, 12'hE41, 0, 0, EM));
    step("irq2", mk(0, 1, N, 12'h000, 0, 0, 12'h041, 0, 12'h000,   0, 0, 12'h000, 0, 0, EM));

    // Reset clears the sticky flag and the stack; reset mid-stall returns to RUN.
    step("rst0", mk(1, 1, N, 12'h000, 0, 0, 12'h050, 0, 12'h000,   1, 0, 12'h000, 0, 0, EM));
`ifdef MF8_PCCTL_STKCHK_EN
    step("uflw", mk(0, 1, R, 12'h000, 0, 0, 12'h060, 0, 12'h000,   0, 0, 12'h000, 0, 0, 0));
`endif
    step("mst0", mk(0, 1, M, 12'h000, 0, 3, 12'h061, 0, 12'h000,   1, 0, 12'h000, 0, 0, EM));
    step("mst1", mk(0, 1, N, 12'h000, 0, 0, 12'h061, 0, 12'h000,   1, 0, 12'h000, 0, 0, EM));
    step("rst1", mk(1, 1, N, 12'h000, 0, 0, 12'h061, 1, 12'h300,   1, 0, 12'h000, 0, 0, EM));
    step("post", mk(0, 1, N, 12'h000, 0, 0, 12'h062, 1, 12'h300,   0, 0, 12'h000, 0, 0, 0));
`ifdef MF8_PCCTL_STKCHK_EN
    step("spz",  mk(0, 1, R, 12'h000, 0, 0, 12'h063, 0, 12'h000,   0, 0, 12'h000, 0, 0, 0));
`else
    step("cal",  mk(0, 1, C, 12'h004, 0, 0, 12'h063, 0, 12'h000,   0, 1, 12'h005, 0, 0, 0));
    step("ret",  mk(0, 1, R, 12'h000, 0, 0, 12'h068, 0, 12'h000,   0, 1, 12'hFFC, 0, 0, 0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
